// File: rtl/call_request_latch.sv
// call_request_latch: synchronise and debounce three call buttons, then latch each as a pending request until its floor is serviced
module call_request_latch #(
  parameter int DEBOUNCE = 4,
  parameter int DWELL = 8,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic floor1,
  input  logic floor2,
  input  logic floor3,
  input  logic door,
  input  logic moving,
  output logic led1,
  output logic led2,
  output logic led3
);
  typedef enum logic [1:0] {IDLE, PENDING, SERVING} state_e;
  logic [2:0] btn, flr, at, press, differ, db_last;
  logic [2:0] s1_q, s2_q, deb_q, deb_d, prev_q, led_q, led_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  logic [CNT_W-1:0] dwell_q, dwell_d;
  state_e state_q [3];
  state_e state_d [3];
  logic legal, dwell_end, hold;
  assign btn = {btn3, btn2, btn1};
  assign flr = {floor3, floor2, floor1};
  assign legal = (flr & (flr - 3'd1)) == 3'd0;
  assign at = flr & {3{door & ~moving & legal}};
  assign press = deb_q & ~prev_q;
  assign dwell_end = dwell_q == CNT_W'(DWELL - 1);
  assign {led3, led2, led1} = led_q;
  always_comb begin
    hold = 1'b0;
    deb_d = deb_q;
    led_d = led_q;
    differ = '0;
    db_last = '0;
    db_cnt_d = db_cnt_q;
    state_d = state_q;
    for (int i = 0; i < 3; i++) begin
      differ[i] = s2_q[i] != deb_q[i];
      db_last[i] = db_cnt_q[i] == CNT_W'(DEBOUNCE - 1);
      db_cnt_d[i] = (differ[i] && !db_last[i]) ? db_cnt_q[i] + 1'b1 : '0;
      deb_d[i] = (differ[i] && db_last[i]) ? s2_q[i] : deb_q[i];
      state_d[i] = state_q[i] == IDLE ? ((press[i] && !at[i]) ? PENDING : IDLE)
                 : state_q[i] == PENDING ? (at[i] ? SERVING : PENDING)
                 : !at[i] ? PENDING
                 : (dwell_end && !press[i]) ? IDLE : SERVING;
      hold = hold | (state_q[i] == SERVING && at[i] && !press[i] && !dwell_end);
      led_d[i] = state_q[i] != IDLE;
    end
    dwell_d = hold ? dwell_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      prev_q <= '0;
      led_q <= '0;
      dwell_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      deb_q <= deb_d;
      prev_q <= deb_q;
      led_q <= led_d;
      dwell_q <= dwell_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end
endmodule

// File: tb/tb_call_request_latch.sv
// tb_call_request_latch: directed scoreboard bench for call_request_latch
module tb_call_request_latch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
  logic floor1 = 1'b1, floor2 = 1'b0, floor3 = 1'b0;
  logic door = 1'b1, moving = 1'b0;
  logic led1, led2, led3;
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q [$];
  string tag_q [$];
  call_request_latch #(.DEBOUNCE(4), .DWELL(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .floor1(floor1), .floor2(floor2), .floor3(floor3),
    .door(door), .moving(moving), .led1(led1), .led2(led2), .led3(led3)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic [2:0] e, input string t);
    logic [2:0] got, want;
    string tg;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    got = {led3, led2, led1};
    want = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tg, got, want);
    end
  endtask
  task automatic set_btn(input logic [2:0] b);
    {btn3, btn2, btn1} = b;
  endtask
  task automatic press(input logic [2:0] b);
    set_btn(b);
    repeat (8) tick();
    set_btn(3'b000);
    repeat (6) tick();
  endtask
  initial begin
    repeat (2) step(3'b000, "reset");
    rst = 1'b0;
    repeat (20) step(3'b000, "idle");
    set_btn(3'b100);
    for (int i = 0; i < 7; i++) step(3'b000, "btn3_latency");
    step(3'b100, "btn3_rise");
    set_btn(3'b000);
    repeat (8) step(3'b100, "btn3_hold");
    set_btn(3'b010);
    repeat (3) step(3'b100, "glitch");
    set_btn(3'b000);
    repeat (10) step(3'b100, "glitch_after");
    checks++;
    assert (dut.db_cnt_q[1] === 8'd0) else begin
      errors++;
      $error("FAIL glitch_cnt got=%0d exp=0", dut.db_cnt_q[1]);
    end
    press(3'b010);
    step(3'b110, "led2_pend");
    floor1 = 1'b0;
    floor2 = 1'b1;
    repeat (9) step(3'b110, "serve2");
    step(3'b100, "serve2_clear");
    door = 1'b0;
    press(3'b010);
    step(3'b110, "led2_repend");
    door = 1'b1;
    repeat (4) step(3'b110, "serve2b");
    door = 1'b0;
    repeat (6) step(3'b110, "door_drop");
    door = 1'b1;
    repeat (9) step(3'b110, "reserve2");
    step(3'b100, "reserve2_clear");
    door = 1'b0;
    floor2 = 1'b0;
    floor1 = 1'b1;
    press(3'b001);
    step(3'b101, "led1_pend");
    set_btn(3'b001);
    door = 1'b1;
    repeat (15) step(3'b101, "extend");
    step(3'b100, "extend_clear");
    set_btn(3'b000);
    repeat (6) step(3'b100, "extend_release");
    set_btn(3'b001);
    repeat (8) step(3'b100, "ignore_press");
    set_btn(3'b000);
    repeat (6) step(3'b100, "ignore_release");
    door = 1'b0;
    press(3'b001);
    step(3'b101, "led1_pend2");
    floor2 = 1'b1;
    door = 1'b1;
    repeat (12) step(3'b101, "illegal_floors");
    floor2 = 1'b0;
    repeat (9) step(3'b101, "legal_serve");
    step(3'b100, "legal_clear");
    door = 1'b0;
    press(3'b011);
    step(3'b111, "all_pend");
    rst = 1'b1;
    step(3'b000, "mid_reset");
    rst = 1'b0;
    repeat (10) step(3'b000, "post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
